// File: rtl/cpu_defs_pkg.sv
// Shared opcode/funct encodings and multiply/divide FSM states for the EX stage.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  function automatic logic is_md_funct(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: arithmetic, logic, shifts, compares, HI/LO reads and branch conditions.
module alu
  import cpu_defs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      i_opcode,
  input  logic [5:0]      i_funct,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  input  logic [XLEN-1:0] i_immSext,
  input  logic [XLEN-1:0] i_immZext,
  input  logic [4:0]      i_shamt,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  output logic [XLEN-1:0] o_result,
  output logic            o_branchTaken
);

  // Anything not decoded, including mult/div and j, yields zero.
  always_comb begin
    o_result      = '0;
    o_branchTaken = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_ADDU: o_result = i_rs + i_rt;
          FN_SUB, FN_SUBU: o_result = i_rs - i_rt;
          FN_AND:  o_result = i_rs & i_rt;
          FN_OR:   o_result = i_rs | i_rt;
          FN_XOR:  o_result = i_rs ^ i_rt;
          FN_NOR:  o_result = ~(i_rs | i_rt);
          FN_SLT:  o_result = XLEN'($signed(i_rs) < $signed(i_rt));
          FN_SLTU: o_result = XLEN'(i_rs < i_rt);
          FN_SLL:  o_result = i_rt << i_shamt;
          FN_SRL:  o_result = i_rt >> i_shamt;
          FN_SRA:  o_result = $signed(i_rt) >>> i_shamt;
          FN_SLLV: o_result = i_rt << i_rs[4:0];
          FN_SRLV: o_result = i_rt >> i_rs[4:0];
          FN_SRAV: o_result = $signed(i_rt) >>> i_rs[4:0];
          FN_MFHI: o_result = i_hi;
          FN_MFLO: o_result = i_lo;
          default: o_result = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: o_result = i_rs + i_immSext;
      OP_SLTI:  o_result = XLEN'($signed(i_rs) < $signed(i_immSext));
      OP_SLTIU: o_result = XLEN'(i_rs < i_immSext);
      OP_ANDI:  o_result = i_rs & i_immZext;
      OP_ORI:   o_result = i_rs | i_immZext;
      OP_XORI:  o_result = i_rs ^ i_immZext;
      OP_LUI:   o_result = i_immSext << 16;
      OP_BEQ:   o_branchTaken = (i_rs == i_rt);
      OP_BNE:   o_branchTaken = (i_rs != i_rt);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide on operand magnitudes with final sign correction; owns HI/LO.
module mul_div_unit
  import cpu_defs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [5:0]      i_funct,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  output logic            o_stall,
  output logic            o_bubble,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_t       r_state;
  logic [CW-1:0]   r_count;
  logic            r_isDiv, r_negQ, r_negRem, r_divZero;
  logic [XLEN-1:0] r_opB, r_accHi, r_accLo, r_hi, r_lo;

  logic            w_isSigned, w_isDiv, w_signA, w_signB;
  logic [XLEN-1:0] w_magA, w_magB;
  logic [XLEN:0]   w_prodSum, w_shifted, w_trial;
  logic [XLEN-1:0] w_nextHi, w_nextLo, w_finHi, w_finLo;
  logic [2*XLEN-1:0] w_prod;

  assign w_isSigned = (i_funct == FN_MULT) || (i_funct == FN_DIV);
  assign w_isDiv    = (i_funct == FN_DIV) || (i_funct == FN_DIVU);
  assign w_signA    = w_isSigned & i_rs[XLEN-1];
  assign w_signB    = w_isSigned & i_rt[XLEN-1];
  assign w_magA     = w_signA ? -i_rs : i_rs;
  assign w_magB     = w_signB ? -i_rt : i_rt;

  // One shift-add (multiply) or restoring-subtract (divide) step on {accHi, accLo}.
  always_comb begin
    w_prodSum = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : '0);
    w_shifted = {r_accHi, r_accLo[XLEN-1]};
    w_trial   = w_shifted - {1'b0, r_opB};
    if (r_isDiv) begin
      if (!w_trial[XLEN]) begin
        w_nextHi = w_trial[XLEN-1:0];
        w_nextLo = {r_accLo[XLEN-2:0], 1'b1};
      end else begin
        w_nextHi = w_shifted[XLEN-1:0];
        w_nextLo = {r_accLo[XLEN-2:0], 1'b0};
      end
    end else begin
      {w_nextHi, w_nextLo} = {w_prodSum, r_accLo[XLEN-1:1]};
    end
  end

  // Divide by zero leaves the dividend in HI naturally; only LO is overridden.
  always_comb begin
    w_prod = {w_nextHi, w_nextLo};
    if (r_negQ) w_prod = -w_prod;
    if (r_isDiv) begin
      w_finLo = r_divZero ? '1 : (r_negQ ? -w_nextLo : w_nextLo);
      w_finHi = r_negRem ? -w_nextHi : w_nextHi;
    end else begin
      w_finHi = w_prod[2*XLEN-1:XLEN];
      w_finLo = w_prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MD_IDLE;
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_opB     <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_isDiv   <= w_isDiv;
            r_negQ    <= w_signA ^ w_signB;
            r_negRem  <= w_signA;
            r_divZero <= (i_rt == '0);
            r_opB     <= w_magB;
            r_accHi   <= '0;
            r_accLo   <= w_magA;
            r_count   <= '0;
            r_state   <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_accHi <= w_nextHi;
          r_accLo <= w_nextLo;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_hi    <= w_finHi;
            r_lo    <= w_finLo;
            r_state <= MD_DONE;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_stall  = rst_n && (((r_state == MD_IDLE) && i_start) || (r_state == MD_BUSY));
  assign o_bubble = o_stall || (r_state == MD_DONE);
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: EX/MEM pipeline register, result muxing and branch/jump targets.
module execute_stage
  import cpu_defs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [XLEN-1:0] PCPlus4_in,
  input  logic [XLEN-1:0] imm_signExtended,
  input  logic [XLEN-1:0] imm_zeroExtended,
  input  logic [4:0]      rt_addr_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [4:0]      shamt_in,
  input  logic [25:0]     address_Jtype_in,
  input  logic [XLEN-1:0] rs_reg,
  input  logic [XLEN-1:0] rt_reg,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            RegDstD,
  input  logic [5:0]      ALUopD,
  input  logic [5:0]      ALUfunctD,
  output logic            stall_out,
  output logic            RegWriteE,
  output logic            MemtoRegE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [XLEN-1:0] alu_result,
  output logic            branch_taken,
  output logic [XLEN-1:0] write_data,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] PC_branch,
  output logic [XLEN-1:0] PC_jump
);

  logic            w_isMd, w_bubble, w_branchTaken;
  logic [XLEN-1:0] w_hi, w_lo, w_aluResult, w_pcBranch, w_pcJump;

  assign w_isMd     = (ALUopD == OP_RTYPE) && is_md_funct(ALUfunctD);
  assign w_pcBranch = PCPlus4_in + (imm_signExtended << 2);
  assign w_pcJump   = {PCPlus4_in[XLEN-1:XLEN-4], address_Jtype_in, 2'b00};

  alu #(.XLEN(XLEN)) u_alu (
    .i_opcode      (ALUopD),
    .i_funct       (ALUfunctD),
    .i_rs          (rs_reg),
    .i_rt          (rt_reg),
    .i_immSext     (imm_signExtended),
    .i_immZext     (imm_zeroExtended),
    .i_shamt       (shamt_in),
    .i_hi          (w_hi),
    .i_lo          (w_lo),
    .o_result      (w_aluResult),
    .o_branchTaken (w_branchTaken)
  );

  mul_div_unit #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_mdu (
    .clk      (CLK),
    .rst_n    (RST_N),
    .i_start  (w_isMd),
    .i_funct  (ALUfunctD),
    .i_rs     (rs_reg),
    .i_rt     (rt_reg),
    .o_stall  (stall_out),
    .o_bubble (w_bubble),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // During a mult/div stall and its trailing DONE cycle the control bits are
  // squashed while the data fields simply hold their last values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWriteE    <= 1'b0;
      MemtoRegE    <= 1'b0;
      MemWriteE    <= 1'b0;
      BranchE      <= 1'b0;
      JumpE        <= 1'b0;
      alu_result   <= '0;
      branch_taken <= 1'b0;
      write_data   <= '0;
      wb_addr      <= '0;
      PC_branch    <= '0;
      PC_jump      <= '0;
    end else if (w_bubble) begin
      RegWriteE    <= 1'b0;
      MemtoRegE    <= 1'b0;
      MemWriteE    <= 1'b0;
      BranchE      <= 1'b0;
      JumpE        <= 1'b0;
    end else begin
      RegWriteE    <= RegWriteD;
      MemtoRegE    <= MemtoRegD;
      MemWriteE    <= MemWriteD;
      BranchE      <= BranchD;
      JumpE        <= JumpD;
      alu_result   <= w_aluResult;
      branch_taken <= w_branchTaken;
      write_data   <= rt_reg;
      wb_addr      <= RegDstD ? rd_addr_in : rt_addr_in;
      PC_branch    <= w_pcBranch;
      PC_jump      <= w_pcJump;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases followed by random
// instructions compared against an arithmetic model of the EX stage.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] PCPlus4_in = '0, imm_signExtended = '0, imm_zeroExtended = '0;
  logic [4:0]  rt_addr_in = '0, rd_addr_in = '0, shamt_in = '0;
  logic [25:0] address_Jtype_in = '0;
  logic [31:0] rs_reg = '0, rt_reg = '0;
  logic        RegWriteD = 0, MemtoRegD = 0, MemWriteD = 0, BranchD = 0, JumpD = 0, RegDstD = 0;
  logic [5:0]  ALUopD = '0, ALUfunctD = '0;
  logic        stall_out, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, branch_taken;
  logic [31:0] alu_result, write_data, PC_branch, PC_jump;
  logic [4:0]  wb_addr;

  execute_stage dut (
    .CLK(CLK), .RST_N(RST_N), .PCPlus4_in(PCPlus4_in),
    .imm_signExtended(imm_signExtended), .imm_zeroExtended(imm_zeroExtended),
    .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in), .shamt_in(shamt_in),
    .address_Jtype_in(address_Jtype_in), .rs_reg(rs_reg), .rt_reg(rt_reg),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .ALUfunctD(ALUfunctD), .stall_out(stall_out),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .alu_result(alu_result),
    .branch_taken(branch_taken), .write_data(write_data), .wb_addr(wb_addr),
    .PC_branch(PC_branch), .PC_jump(PC_jump)
  );

  always #5 CLK = ~CLK;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] modelHi = '0, modelLo = '0;

  logic [5:0]  tOp, tFn, tCtrl;
  logic [31:0] tRs, tRt, tPc;
  logic [15:0] tImm;
  logic [4:0]  tShamt, tRd, tRtA;
  logic [25:0] tJ;

  localparam logic [11:0] OP_TABLE [33] = '{
    12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
    12'h02A, 12'h02B, 12'h000, 12'h002, 12'h003, 12'h004, 12'h006, 12'h007,
    12'h010, 12'h012, 12'h001,
    12'h200, 12'h240, 12'h280, 12'h2C0, 12'h300, 12'h340, 12'h380, 12'h3C0,
    12'h8C0, 12'hAC0, 12'h100, 12'h140, 12'h080, 12'hFC0
  };

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelAlu(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [31:0] rs, input logic [31:0] rt,
                                           input logic [15:0] imm, input logic [4:0] sh,
                                           input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] sext, zext;
    sext = {{16{imm[15]}}, imm};
    zext = {16'h0000, imm};
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return rs + rt;
        6'h22, 6'h23: return rs - rt;
        6'h24: return rs & rt;
        6'h25: return rs | rt;
        6'h26: return rs ^ rt;
        6'h27: return ~(rs | rt);
        6'h2A: return ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
        6'h2B: return (rs < rt) ? 32'd1 : 32'd0;
        6'h00: return rt << sh;
        6'h02: return rt >> sh;
        6'h03: return $signed(rt) >>> sh;
        6'h04: return rt << rs[4:0];
        6'h06: return rt >> rs[4:0];
        6'h07: return $signed(rt) >>> rs[4:0];
        6'h10: return hi;
        6'h12: return lo;
        default: return 32'd0;
      endcase
    end
    case (op)
      6'h08, 6'h09, 6'h23, 6'h2B: return rs + sext;
      6'h0A: return ($signed(rs) < $signed(sext)) ? 32'd1 : 32'd0;
      6'h0B: return (rs < sext) ? 32'd1 : 32'd0;
      6'h0C: return rs & zext;
      6'h0D: return rs | zext;
      6'h0E: return rs ^ zext;
      6'h0F: return {imm, 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelMd(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] p;
    case (fn)
      6'h18: begin
        p = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        {modelHi, modelLo} = p;
      end
      6'h19: begin
        p = {32'h0, rs} * {32'h0, rt};
        {modelHi, modelLo} = p;
      end
      6'h1A: begin
        if (rt == 0) begin modelLo = 32'hFFFFFFFF; modelHi = rs; end
        else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) begin modelLo = 32'h80000000; modelHi = 0; end
        else begin modelLo = $signed(rs) / $signed(rt); modelHi = $signed(rs) % $signed(rt); end
      end
      default: begin
        if (rt == 0) begin modelLo = 32'hFFFFFFFF; modelHi = rs; end
        else begin modelLo = rs / rt; modelHi = rs % rt; end
      end
    endcase
  endtask

  task automatic driveInputs();
    ALUopD = tOp; ALUfunctD = tFn; rs_reg = tRs; rt_reg = tRt;
    imm_signExtended = {{16{tImm[15]}}, tImm}; imm_zeroExtended = {16'h0000, tImm};
    shamt_in = tShamt; rd_addr_in = tRd; rt_addr_in = tRtA;
    PCPlus4_in = tPc; address_Jtype_in = tJ;
    {RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD} = tCtrl;
  endtask

  task automatic applyStimulus();
    driveInputs();
    @(posedge CLK);
    #1;
  endtask

  task automatic setInstr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] sh);
    tOp = op; tFn = fn; tRs = rs; tRt = rt; tImm = imm; tShamt = sh;
    tRd = 5'd5; tRtA = 5'd9; tPc = 32'h00000100; tJ = 26'h0ABCDEF; tCtrl = 6'b100001;
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] sext;
    logic expBr;
    sext  = {{16{tImm[15]}}, tImm};
    expBr = (tOp == 6'h04 && tRs == tRt) || (tOp == 6'h05 && tRs != tRt);
    checkOutput({tag, ".alu"}, alu_result, modelAlu(tOp, tFn, tRs, tRt, tImm, tShamt, modelHi, modelLo));
    checkOutput({tag, ".br"}, {31'b0, branch_taken}, {31'b0, expBr});
    checkOutput({tag, ".wdata"}, write_data, tRt);
    checkOutput({tag, ".wb"}, {27'b0, wb_addr}, {27'b0, tCtrl[0] ? tRd : tRtA});
    checkOutput({tag, ".pcb"}, PC_branch, tPc + (sext << 2));
    checkOutput({tag, ".pcj"}, PC_jump, {tPc[31:28], tJ, 2'b00});
    checkOutput({tag, ".ctrl"}, {27'b0, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE},
                {27'b0, tCtrl[5:1]});
    checkOutput({tag, ".stall"}, {31'b0, stall_out}, 32'd0);
  endtask

  task automatic runMd(input string tag, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    int stallCycles;
    int badBubble;
    setInstr(6'h00, fn, rs, rt, 16'h0000, 5'd0);
    tCtrl = 6'b111111;
    driveInputs();
    #1;
    stallCycles = 0;
    badBubble = 0;
    for (int c = 0; c < 40 && stall_out; c++) begin
      stallCycles++;
      @(posedge CLK);
      #1;
      if ({RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE} != 5'b0) badBubble++;
    end
    checkOutput({tag, ".stallCycles"}, stallCycles, 32'd33);
    checkOutput({tag, ".stallBubbles"}, badBubble, 32'd0);
    @(posedge CLK);
    #1;
    checkOutput({tag, ".doneBubble"}, {27'b0, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE}, 32'd0);
    modelMd(fn, rs, rt);
  endtask

  task automatic readHiLo(input string tag, input logic [31:0] expLo, input logic [31:0] expHi, input bit useConst);
    setInstr(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, 5'd0);
    applyStimulus();
    checkAll({tag, ".mflo"});
    if (useConst) checkOutput({tag, ".lo"}, alu_result, expLo);
    setInstr(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0);
    applyStimulus();
    checkAll({tag, ".mfhi"});
    if (useConst) checkOutput({tag, ".hi"}, alu_result, expHi);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] entry;
    logic [5:0]  mdFn;
    logic [31:0] mdRt;

    // Reset state
    setInstr(6'h00, 6'h00, 32'h0, 32'h0, 16'h0, 5'd0);
    tCtrl = 6'b0;
    driveInputs();
    #12;
    checkOutput("reset.alu", alu_result, 32'd0);
    checkOutput("reset.ctrl", {27'b0, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE}, 32'd0);
    checkOutput("reset.stall", {31'b0, stall_out}, 32'd0);
    checkOutput("reset.pcb", PC_branch, 32'd0);
    RST_N = 1'b1;

    setInstr(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0);
    applyStimulus();
    checkAll("init.mfhi");

    setInstr(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0, 5'd0);
    applyStimulus();
    checkAll("add");
    checkOutput("add.const", alu_result, 32'h80000000);
    checkOutput("add.regwrite", {31'b0, RegWriteE}, 32'd1);
    checkOutput("add.wbaddr", {27'b0, wb_addr}, 32'd5);

    setInstr(6'h04, 6'h00, 32'd3, 32'd3, 16'hFFFE, 5'd0);
    tCtrl = 6'b000100;
    applyStimulus();
    checkAll("beq");
    checkOutput("beq.taken", {31'b0, branch_taken}, 32'd1);
    checkOutput("beq.target", PC_branch, 32'h000000F8);
    tOp = 6'h05;
    applyStimulus();
    checkAll("bne");
    checkOutput("bne.taken", {31'b0, branch_taken}, 32'd0);

    setInstr(6'h00, 6'h03, 32'h0, 32'h80000000, 16'h0, 5'd4);
    applyStimulus();
    checkAll("sra");
    checkOutput("sra.const", alu_result, 32'hF8000000);
    setInstr(6'h0F, 6'h00, 32'h0, 32'h0, 16'h1234, 5'd0);
    applyStimulus();
    checkAll("lui");
    checkOutput("lui.const", alu_result, 32'h12340000);

    runMd("mult", 6'h18, 32'hFFFFFFFD, 32'd7);
    readHiLo("mult", 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b1);
    runMd("divu", 6'h1B, 32'd100, 32'd7);
    readHiLo("divu", 32'd14, 32'd2, 1'b1);
    runMd("divu0", 6'h1B, 32'd100, 32'd0);
    readHiLo("divu0", 32'hFFFFFFFF, 32'd100, 1'b1);
    runMd("divovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    readHiLo("divovf", 32'h80000000, 32'd0, 1'b1);
    runMd("divneg", 6'h1A, 32'hFFFFFFF9, 32'd2);
    readHiLo("divneg", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1);

    // Random instruction stream, with the occasional multiply/divide
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        mdFn = 6'h18 + 6'($urandom_range(0, 3));
        mdRt = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        runMd("randMd", mdFn, $urandom, mdRt);
        readHiLo("randMd", 32'd0, 32'd0, 1'b0);
      end else begin
        entry  = OP_TABLE[$urandom_range(0, 32)];
        tOp    = entry[11:6];
        tFn    = (tOp == 6'h00) ? entry[5:0] : 6'($urandom);
        tRs    = $urandom;
        tRt    = ($urandom_range(0, 3) == 0) ? tRs : $urandom;
        tImm   = 16'($urandom);
        tShamt = 5'($urandom);
        tRd    = 5'($urandom);
        tRtA   = 5'($urandom);
        tPc    = $urandom & 32'hFFFFFFFC;
        tJ     = 26'($urandom);
        tCtrl  = 6'($urandom);
        applyStimulus();
        checkAll("rand");
      end
    end

    // Reset in the middle of a divide aborts it and clears HI/LO
    setInstr(6'h00, 6'h1A, 32'd1000, 32'd3, 16'h0, 5'd0);
    tCtrl = 6'b111111;
    driveInputs();
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("midReset.alu", alu_result, 32'd0);
    checkOutput("midReset.wdata", write_data, 32'd0);
    checkOutput("midReset.wb", {27'b0, wb_addr}, 32'd0);
    checkOutput("midReset.ctrl", {27'b0, RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE}, 32'd0);
    checkOutput("midReset.stall", {31'b0, stall_out}, 32'd0);
    modelHi = '0;
    modelLo = '0;
    setInstr(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 5'd0);
    driveInputs();
    #2;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkAll("postReset.mfhi");
    checkOutput("postReset.hi", alu_result, 32'd0);
    readHiLo("postReset", 32'd0, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
